// File: rtl/reg_trace_fifo.sv
// ---------------------------------------------------------------------------
// reg_trace_fifo
//
// Retirement trace buffer placed downstream of the CPU core. Each retire
// strobe captures {opcode, A,B,C,D,E,H,L,F} into a FIFO. A small two-state
// FSM pops entries into a shift register and streams them out one byte per
// handshake on a valid/ready port, with the most significant byte first:
// op, A, B, C, D, E, H, L, F. out_last marks the F byte.
//
// Optional feature (macro TRACE_SEQNUM_EN):
//   A 16-bit retire sequence counter advances on every retire, whether the
//   entry is accepted or dropped. Each stored entry carries the counter value,
//   and seq[15:8], seq[7:0] are sent ahead of the opcode (11 bytes/entry).
//   Dropped retires therefore show up as gaps in the sequence. Without the
//   macro there is no counter and each entry is 9 bytes.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous active-high reset; flushes FIFO and transfer
//   retire      in   one-cycle strobe, instruction retired this cycle
//   retire_op   in   opcode of the retiring instruction
//   retire_regs in   register snapshot {A,B,C,D,E,H,L,F}, A in the top byte
//   out_valid   out  out_byte holds a valid trace byte
//   out_ready   in   sink accepts out_byte when out_valid && out_ready
//   out_byte    out  serialized trace byte
//   out_last    out  out_byte is the final byte of the current entry
//   count       out  FIFO entries stored, excluding the entry being sent
//   overflow    out  sticky: a retire was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module reg_trace_fifo #(
  parameter int OP_SIZE  = 8,
  parameter int RES_SIZE = 64,
  parameter int DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      retire,
  input  logic [OP_SIZE-1:0]        retire_op,
  input  logic [RES_SIZE-1:0]       retire_regs,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_byte,
  output logic                      out_last,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef TRACE_SEQNUM_EN
  localparam int SEQ_W = 16;
`else
  localparam int SEQ_W = 0;
`endif
  localparam int EW     = SEQ_W + OP_SIZE + RES_SIZE;
  localparam int NBYTES = EW / 8;
  localparam int IW     = $clog2(NBYTES);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_reg, state_next;
  logic [EW-1:0]   shift_reg, shift_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            valid_reg, valid_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            overflow_reg;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   entry_in;
  logic            push, pop, handshake, last_byte;

`ifdef TRACE_SEQNUM_EN
  logic [15:0]     seq_reg;
  assign entry_in = {seq_reg, retire_op, retire_regs};
`else
  assign entry_in = {retire_op, retire_regs};
`endif

  assign handshake = valid_reg && out_ready;
  assign last_byte = (idx_reg == LAST_IDX);

  // A full FIFO still accepts a retire when the same edge pops the head,
  // because the slot being freed is the one the write pointer lands on.
  assign push = retire && ((count_reg != FULL_CNT) || pop);

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          idx_next   = '0;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!last_byte) begin
            shift_next = shift_reg << 8;
            idx_next   = idx_reg + 1'b1;
          end else if (count_reg != '0) begin
            // Back-to-back entries: load the next one with no idle bubble.
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            idx_next   = '0;
          end else begin
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      idx_reg      <= '0;
      valid_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
`ifdef TRACE_SEQNUM_EN
      seq_reg      <= '0;
`endif
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (retire && !push) overflow_reg <= 1'b1;
`ifdef TRACE_SEQNUM_EN
      if (retire) seq_reg <= seq_reg + 16'd1;
`endif
    end
  end

  // Storage array has no reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= entry_in;
  end

  assign out_valid = valid_reg;
  assign out_byte  = shift_reg[EW-1 -: 8];
  assign out_last  = valid_reg && last_byte;
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_reg_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_reg_trace_fifo
//
// Directed bench for reg_trace_fifo (DEPTH=16). Covers single-entry latency
// and byte order, backpressure stability, fill/overflow/in-order drain,
// push accepted on the edge that frees the full FIFO, and reset mid-entry.
// With TRACE_SEQNUM_EN defined, entries also carry expected sequence numbers,
// including the gap left by a dropped retire.
// ---------------------------------------------------------------------------
module tb_reg_trace_fifo;

  localparam int DEPTH = 16;
`ifdef TRACE_SEQNUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        retire;
  logic [7:0]  retire_op;
  logic [63:0] retire_regs;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [4:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  reg_trace_fifo #(.OP_SIZE(8), .RES_SIZE(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .retire(retire), .retire_op(retire_op),
    .retire_regs(retire_regs), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] seq, input logic [7:0] op,
                                          input logic [63:0] regs, input int i);
    logic [87:0] v;
    v = {seq, op, regs};
    return v[(NB-1-i)*8 +: 8];
  endfunction

  function automatic logic [7:0] pat_op(input int k);
    return 8'(8'h10 + k);
  endfunction

  function automatic logic [63:0] pat_regs(input int k);
    return {8{8'(k)}} ^ 64'hF0E1D2C3B4A59687;
  endfunction

  task automatic do_retire(input logic [7:0] op, input logic [63:0] regs);
    retire      = 1'b1;
    retire_op   = op;
    retire_regs = regs;
    tick();
    retire      = 1'b0;
    retire_op   = 'x;
    retire_regs = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Receive one whole entry with out_ready=1 on entry; optionally stall at
  // byte stall_at for five cycles and check the port holds still.
  task automatic recv_entry(input string tag, input logic [15:0] seq, input logic [7:0] op,
                            input logic [63:0] regs, input int stall_at);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    for (int i = 0; i < NB; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check({tag, ".stall_byte"}, 64'(out_byte), 64'(exp_byte(seq, op, regs, i)));
          check({tag, ".stall_last"}, 64'(out_last), 64'(i == NB-1));
          check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
      end
      check({tag, ".byte"}, 64'(out_byte), 64'(exp_byte(seq, op, regs, i)));
      check({tag, ".last"}, 64'(out_last), 64'(i == NB-1));
      tick();
    end
    $display("entry %s seq=%04h op=%02h received", tag, seq, op);
  endtask

  initial begin
    rst         = 1'b0;
    retire      = 1'b0;
    retire_op   = '0;
    retire_regs = '0;
    out_ready   = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.byte", 64'(out_byte), 64'd0);
    check("rst.last", 64'(out_last), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.overflow", 64'(overflow), 64'd0);

    // 1: single entry latency and byte order
    do_retire(8'h3E, 64'h0102030405060708);
    check("t1.valid_after_push", 64'(out_valid), 64'd0);
    check("t1.count_after_push", 64'(count), 64'd1);
    tick();
    check("t1.valid_after_pop", 64'(out_valid), 64'd1);
    check("t1.count_after_pop", 64'(count), 64'd0);
    recv_entry("t1", 16'd0, 8'h3E, 64'h0102030405060708, -1);
    check("t1.idle_valid", 64'(out_valid), 64'd0);

    // 2: backpressure mid-entry
    do_retire(8'hA5, 64'h1122334455667788);
    recv_entry("t2", 16'd1, 8'hA5, 64'h1122334455667788, 4);
    check("t2.idle_valid", 64'(out_valid), 64'd0);

    // 3: fill with ready low; DEPTH+1 accepted (one in the shift register), one dropped
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) do_retire(pat_op(k), pat_regs(k));
    check("t3.count_full", 64'(count), 64'(DEPTH));
    check("t3.overflow_before_drop", 64'(overflow), 64'd0);
    do_retire(8'hEE, 64'hDEADBEEFDEADBEEF);
    check("t3.overflow_after_drop", 64'(overflow), 64'd1);
    check("t3.count_after_drop", 64'(count), 64'(DEPTH));
    out_ready = 1'b1;
    for (int k = 0; k <= DEPTH; k++)
      recv_entry($sformatf("t3.e%0d", k), 16'(k), pat_op(k), pat_regs(k), -1);
    check("t3.drained_valid", 64'(out_valid), 64'd0);
    check("t3.drained_count", 64'(count), 64'd0);
    check("t3.overflow_sticky", 64'(overflow), 64'd1);
    // Sequence number DEPTH+1 was consumed by the dropped retire.
    do_retire(8'h5A, 64'hCAFEF00D12345678);
    recv_entry("t3.gap", 16'(DEPTH+2), 8'h5A, 64'hCAFEF00D12345678, -1);

    // 4: full FIFO, retire on the edge of the final-byte handshake
    do_reset();
    check("t4.overflow_cleared", 64'(overflow), 64'd0);
    out_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) do_retire(pat_op(k), pat_regs(k));
    check("t4.count_full", 64'(count), 64'(DEPTH));
    out_ready = 1'b1;
    for (int i = 0; i < NB-1; i++) tick();
    check("t4.at_last", 64'(out_last), 64'd1);
    do_retire(8'h99, 64'h0F0E0D0C0B0A0908);
    check("t4.count_stays", 64'(count), 64'(DEPTH));
    check("t4.no_overflow", 64'(overflow), 64'd0);
    check("t4.next_valid", 64'(out_valid), 64'd1);
    check("t4.next_byte0", 64'(out_byte), 64'(exp_byte(16'd1, pat_op(1), pat_regs(1), 0)));

    // 5: reset mid-entry at byte 4, then a fresh entry starts from byte 0
    do_reset();
    do_retire(8'h42, 64'h8877665544332211);
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("t5.byte4", 64'(out_byte), 64'(exp_byte(16'd0, 8'h42, 64'h8877665544332211, 4)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5.valid", 64'(out_valid), 64'd0);
    check("t5.count", 64'(count), 64'd0);
    check("t5.overflow", 64'(overflow), 64'd0);
    do_retire(8'h77, 64'h0123456789ABCDEF);
    recv_entry("t5", 16'd0, 8'h77, 64'h0123456789ABCDEF, -1);
    check("t5.idle_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
